// File: rtl/conv_fix_seq_if.sv
// Host/register and datapath-facing signals of the conv_fix sequencer.
// slave is the sequencer's view; master is the host plus datapath side.
interface conv_fix_seq_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              start;
    logic [ADDR_W:0]   len;
    logic              busy;
    logic              done;
    logic [1:0]        err;
    logic              wr_err;
    logic              conv_rst;
    logic [DATA_W-1:0] conv_a;
    logic [DATA_W-1:0] conv_result;
    logic              conv_ovalid;
    logic              conv_end;
    logic [DATA_W-1:0] res_data;
    logic              res_valid;
    logic [ADDR_W:0]   res_count;

    modport slave (
        input  wr_en, wr_addr, wr_data, start, len, conv_result, conv_ovalid, conv_end,
        output busy, done, err, wr_err, conv_rst, conv_a, res_data, res_valid, res_count
    );

    modport master (
        output wr_en, wr_addr, wr_data, start, len, conv_result, conv_ovalid, conv_end,
        input  busy, done, err, wr_err, conv_rst, conv_a, res_data, res_valid, res_count
    );
endinterface

// File: rtl/conv_fix_seq.sv
// Sequencer for conv_fix: clears the datapath, streams the preloaded sample
// buffer onto conv_a, captures results and finishes on conv_end or timeout.
module conv_fix_seq #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 4,
    parameter int CLR_CYC = 2,
    parameter int TIMEOUT = 64
) (
    input  logic          clock,
    input  logic          rst,
    conv_fix_seq_if.slave bus
);
    localparam int CNT_W = $clog2((TIMEOUT > CLR_CYC) ? TIMEOUT : CLR_CYC) + 1;

    typedef enum logic [2:0] {IDLE, CLR, FEED, DRAIN, DONE} state_t;

    state_t            state;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] idx_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W:0]   len_sat;
    logic [DATA_W-1:0] mem [DEPTH];

    assign idx_nxt = idx + 1'b1;
    assign len_sat = (bus.len > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : bus.len;

    // Sample buffer has no reset; host writes are only accepted while idle.
    always_ff @(posedge clock) begin
        if (bus.wr_en && !bus.busy) mem[bus.wr_addr] <= bus.wr_data;
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.err       <= 2'b00;
            bus.wr_err    <= 1'b0;
            bus.conv_rst  <= 1'b1;
            bus.conv_a    <= '0;
            bus.res_data  <= '0;
            bus.res_valid <= 1'b0;
            bus.res_count <= '0;
            len_q         <= '0;
            idx           <= '0;
            cnt           <= '0;
        end else begin
            bus.done   <= 1'b0;
            bus.wr_err <= bus.wr_en && bus.busy;

            // Results are only meaningful while the datapath is out of reset.
            if (state == FEED || state == DRAIN) begin
                bus.res_valid <= bus.conv_ovalid;
                if (bus.conv_ovalid) begin
                    bus.res_data <= bus.conv_result;
                    if (bus.res_count != '1) bus.res_count <= bus.res_count + 1'b1;
                end
            end else begin
                bus.res_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        len_q         <= len_sat;
                        bus.res_count <= '0;
                        bus.err       <= 2'b00;
                        bus.busy      <= 1'b1;
                        cnt           <= '0;
                        if (len_sat == '0) begin
                            state    <= DONE;
                            bus.done <= 1'b1;
                        end else begin
                            state <= CLR;
                        end
                    end
                end
                CLR: begin
                    if (cnt == CNT_W'(CLR_CYC - 1)) begin
                        state        <= FEED;
                        bus.conv_rst <= 1'b0;
                        bus.conv_a   <= mem[0];
                        idx          <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                FEED: begin
                    if (bus.conv_end) begin
                        bus.err[1]   <= 1'b1;
                        state        <= DONE;
                        bus.done     <= 1'b1;
                        bus.conv_rst <= 1'b1;
                        bus.conv_a   <= '0;
                    end else if ({1'b0, idx} == len_q - 1'b1) begin
                        state      <= DRAIN;
                        bus.conv_a <= '0;
                        cnt        <= '0;
                    end else begin
                        idx        <= idx_nxt;
                        bus.conv_a <= mem[idx_nxt];
                    end
                end
                DRAIN: begin
                    if (bus.conv_end || cnt == CNT_W'(TIMEOUT - 1)) begin
                        if (!bus.conv_end) bus.err[0] <= 1'b1;
                        state        <= DONE;
                        bus.done     <= 1'b1;
                        bus.conv_rst <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
